hazard_controller: RTL and testbench

//  Sequences the 5-stage RV32I pipeline around the decode stage (register read + immediate extend).

---
 rtl/hazard_controller.sv | 148 ++++++++++++++
 tb/tb_hazard_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RV32I pipeline hazard unit: forwarding, stall/flush, memory-wait FSM
// Memory waits are counted by the FSM; a wait timeout latches MemErr and freezes the pipe until reset.
module hazard_controller #(
   parameter int ADDR_WIDTH     = 5,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int WAIT_WIDTH     = 8,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] Rs1D,
   input  logic [ADDR_WIDTH-1:0] Rs2D,
   input  logic [ADDR_WIDTH-1:0] Rs1E,
   input  logic [ADDR_WIDTH-1:0] Rs2E,
   input  logic [ADDR_WIDTH-1:0] RdE,
   input  logic [ADDR_WIDTH-1:0] RdM,
   input  logic [ADDR_WIDTH-1:0] RdW,
   input  logic                  ResultSrcE0,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  PCSrcE,
   input  logic                  MemReqM,
   input  logic                  MemReadyM,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushW,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  MemErr,
   output logic [CNT_WIDTH-1:0]  StallCycles,
   output logic [CNT_WIDTH-1:0]  FlushCount
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_t;

   localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

   state_t                state_q, state_d;
   logic [WAIT_WIDTH-1:0] wait_q, wait_d;
   logic                  mem_err_q, mem_err_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

   logic mem_wait, lw_stall, br_flush;

   assign mem_wait = MemReqM & ~MemReadyM;
   assign lw_stall = ResultSrcE0 & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

   // M-stage result is newer than W, so it wins when both match
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && RdM != '0 && RdM == Rs1E)      ForwardAE = 2'b10;
      else if (RegWriteW && RdW != '0 && RdW == Rs1E) ForwardAE = 2'b01;
      if (RegWriteM && RdM != '0 && RdM == Rs2E)      ForwardBE = 2'b10;
      else if (RegWriteW && RdW != '0 && RdW == Rs2E) ForwardBE = 2'b01;
   end

   always_comb begin
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      StallM   = 1'b0;
      FlushD   = 1'b0;
      FlushE   = 1'b0;
      FlushW   = 1'b0;
      br_flush = 1'b0;
      if (state_q == S_ERROR || mem_wait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD   = 1'b1;
         FlushE   = 1'b1;
         br_flush = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         S_RUN: begin
            if (mem_wait) begin
               if (TIMEOUT_CYCLES == 1) begin
                  state_d   = S_ERROR;
                  mem_err_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  wait_d  = WAIT_WIDTH'(1);
               end
            end
         end
         S_WAIT: begin
            if (!mem_wait) begin
               state_d = S_RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_ERROR;
               mem_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_WIDTH'(1);
            end
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallF && stall_cnt_q != CNT_MAX)   stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (br_flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RUN;
         wait_q      <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign MemErr      = mem_err_q;
   assign StallCycles = stall_cnt_q;
   assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed bench for hazard_controller
// dut uses a 4-cycle timeout; dut2 uses timeout 1 and 4-bit counters for saturation.
module tb_hazard_controller;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic MemReqM2, MemReadyM2;

   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [1:0] ForwardAE, ForwardBE;
   logic [31:0] StallCycles, FlushCount;

   logic StallF2, StallD2, StallE2, StallM2, FlushD2, FlushE2, FlushW2, MemErr2;
   logic [1:0] ForwardAE2, ForwardBE2;
   logic [3:0] StallCycles2, FlushCount2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_controller #(.ADDR_WIDTH(5), .TIMEOUT_CYCLES(4), .WAIT_WIDTH(8), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MemErr(MemErr), .StallCycles(StallCycles), .FlushCount(FlushCount)
   );

   hazard_controller #(.ADDR_WIDTH(5), .TIMEOUT_CYCLES(1), .WAIT_WIDTH(8), .CNT_WIDTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM2), .MemReadyM(MemReadyM2),
      .StallF(StallF2), .StallD(StallD2), .StallE(StallE2), .StallM(StallM2),
      .FlushD(FlushD2), .FlushE(FlushE2), .FlushW(FlushW2),
      .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
      .MemErr(MemErr2), .StallCycles(StallCycles2), .FlushCount(FlushCount2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
      MemReqM = 0; MemReadyM = 0; MemReqM2 = 0; MemReadyM2 = 0;
   endtask

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   function automatic logic [6:0] ctl();
      return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
   endfunction

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #1;
      check("reset_ctl", {25'd0, ctl()}, 32'd0);
      check("reset_cnt", StallCycles | FlushCount, 32'd0);
      check("reset_err", {31'd0, MemErr}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // forwarding, M over W, x0 never forwarded
      RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 0;
      #1;
      check("fwd_a_m_prio", {30'd0, ForwardAE}, 32'd2);
      check("fwd_b_none",   {30'd0, ForwardBE}, 32'd0);
      RegWriteM = 0; Rs2E = 7;
      #1;
      check("fwd_a_w", {30'd0, ForwardAE}, 32'd1);
      check("fwd_b_w", {30'd0, ForwardBE}, 32'd1);
      RegWriteM = 1; RdM = 0; RdW = 0; RdE = 0; Rs1E = 0; Rs2E = 0;
      #1;
      check("fwd_x0", {28'd0, ForwardAE, ForwardBE}, 32'd0);

      // load-use: lw x5 in E, Rs2D=x5
      clear_inputs();
      ResultSrcE0 = 1; RdE = 5; Rs1D = 1; Rs2D = 5;
      #1;
      check("lw_stall_ctl", {25'd0, ctl()}, 32'b1100010);
      tick();
      clear_inputs();
      RegWriteW = 1; RdW = 5; Rs1E = 5;
      #1;
      check("lw_then_fwd", {30'd0, ForwardAE}, 32'd1);
      check("lw_then_ctl", {25'd0, ctl()}, 32'd0);
      check("stall_cnt_lw", StallCycles, 32'd1);
      clear_inputs();
      ResultSrcE0 = 1; RdE = 0; Rs1D = 0;
      #1;
      check("lw_x0_nostall", {25'd0, ctl()}, 32'd0);

      // taken branch beats load-use
      clear_inputs();
      ResultSrcE0 = 1; RdE = 5; Rs1D = 5; PCSrcE = 1;
      #1;
      check("br_ctl", {25'd0, ctl()}, 32'b0000110);
      tick();
      clear_inputs();
      #1;
      check("br_flush_cnt", FlushCount, 32'd1);
      check("br_stall_cnt", StallCycles, 32'd1);

      // request dropped mid-wait counts as complete
      MemReqM = 1;
      tick();
      tick();
      MemReqM = 0;
      #1;
      check("drop_ctl", {25'd0, ctl()}, 32'd0);
      tick();

      // 3-cycle memory wait, branch in E is ignored meanwhile
      MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 3; i++) begin
         PCSrcE = (i == 1);
         #1;
         check($sformatf("memwait_ctl%0d", i), {25'd0, ctl()}, 32'b1111001);
         tick();
      end
      PCSrcE = 0; MemReadyM = 1;
      #1;
      check("memwait_done_ctl", {25'd0, ctl()}, 32'd0);
      tick();
      MemReqM = 0; MemReadyM = 0;
      #1;
      check("memwait_stall_cnt", StallCycles, 32'd6);
      check("memwait_flush_cnt", FlushCount, 32'd1);
      check("memwait_err", {31'd0, MemErr}, 32'd0);

      // timeout after 4 consecutive wait cycles
      MemReqM = 1;
      tick();
      tick();
      tick();
      check("timeout_early", {31'd0, MemErr}, 32'd0);
      tick();
      check("timeout_err", {31'd0, MemErr}, 32'd1);
      MemReadyM = 1; MemReqM = 0; PCSrcE = 1;
      RegWriteM = 1; RdM = 3; Rs1E = 3;
      #1;
      check("error_ctl", {25'd0, ctl()}, 32'b1111001);
      check("error_fwd", {30'd0, ForwardAE}, 32'd2);
      tick();
      check("error_sticky", {31'd0, MemErr}, 32'd1);
      check("error_stall_cnt", StallCycles, 32'd11);

      // reset clears error and counters
      clear_inputs();
      rst_n = 0;
      #1;
      check("rst_err", {31'd0, MemErr}, 32'd0);
      check("rst_cnt", StallCycles | FlushCount, 32'd0);
      check("rst_ctl", {25'd0, ctl()}, 32'd0);
      rst_n = 1;
      tick();

      // reset mid-wait discards the wait count
      MemReqM = 1;
      tick();
      tick();
      #2;
      rst_n = 0;
      #1;
      rst_n = 1;
      tick();
      tick();
      tick();
      check("rst_midwait_err", {31'd0, MemErr}, 32'd0);
      clear_inputs();
      rst_n = 0;
      #1;
      rst_n = 1;
      tick();

      // TIMEOUT_CYCLES=1 and 4-bit counter saturation
      MemReqM2 = 1;
      #1;
      check("t1_first_stall", {31'd0, StallF2}, 32'd1);
      check("t1_no_err_yet", {31'd0, MemErr2}, 32'd0);
      tick();
      check("t1_err", {31'd0, MemErr2}, 32'd1);
      MemReqM2 = 0;
      for (int i = 0; i < 20; i++) tick();
      check("sat_stall_cnt", {28'd0, StallCycles2}, 32'hF);
      check("sat_err_sticky", {31'd0, MemErr2}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
